btn_conditioner: RTL

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_cond_pkg.sv | 23 ++
 rtl/btn_cond_ch.sv | 127 ++++++++++++
 rtl/btn_conditioner.sv | 58 +++++
 3 files changed

// File: rtl/btn_cond_pkg.sv
// rtl/btn_cond_pkg.sv - shared channel state encoding and parameter helpers
package btn_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } ch_state_e;

  // Width of the repeat counter: enough to hold RPT_DLY, never narrower than 1 bit.
  function automatic int rpt_width(input int rpt_dly);
    return (rpt_dly < 1) ? 1 : $clog2(rpt_dly + 1);
  endfunction

  function automatic bit params_ok(input int n_ch, input int n_dc,
                                   input int rpt_dly, input int rpt_per);
    if (n_ch < 1 || n_dc < 1 || rpt_dly < 0) return 1'b0;
    if (rpt_dly > 0 && (rpt_per < 1 || rpt_per > rpt_dly)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/btn_cond_ch.sv
// rtl/btn_cond_ch.sv - one push-button channel: synchronizer, debounce FSM, auto-repeat
import btn_cond_pkg::*;

module btn_cond_ch #(
  parameter int N_DC    = 20,
  parameter int RPT_DLY = 8,
  parameter int RPT_PER = 2
) (
  input  logic ClkPort,
  input  logic Reset,
  input  logic pb,
  output logic dpb,
  output logic scen,
  output logic mcen,
  output logic ccen,
  output logic rcen,
  output logic scen_nxt
);

  localparam int             RW         = rpt_width(RPT_DLY);
  localparam logic [RW-1:0]  RPT_TOP    = RW'(RPT_DLY);
  localparam logic [RW-1:0]  RPT_RELOAD = RW'(RPT_DLY - RPT_PER);

  logic [1:0]      sync_q, sync_d;
  ch_state_e       state_q, state_d, prev_q, prev_d;
  logic [N_DC-1:0] dbc_q, dbc_d, ivl_q, ivl_d;
  logic [RW-1:0]   rpt_q, rpt_d, rpt_inc;
  logic            rpt_hit_q, rpt_hit_d;
  logic            dpb_q, dpb_d, scen_q, scen_d, mcen_q, mcen_d;
  logic            ccen_q, ccen_d, rcen_q, rcen_d;
  logic            sync;

  always_comb begin
    sync_d    = {sync_q[0], pb};
    sync      = sync_q[1];
    state_d   = state_q;
    prev_d    = state_q;
    dbc_d     = dbc_q + 1'b1;
    ivl_d     = ivl_q;
    rpt_d     = rpt_q;
    rpt_inc   = rpt_q + 1'b1;
    rpt_hit_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dbc_d = '0;
        if (sync) state_d = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (!sync) begin
          state_d = ST_IDLE;
        end else if (&dbc_q) begin
          state_d = ST_HELD;
          ivl_d   = '0;
          rpt_d   = '0;
        end
      end
      ST_HELD: begin
        if (!sync) begin
          state_d = ST_RELEASE_WAIT;
          dbc_d   = '0;
        end else begin
          ivl_d = ivl_q + 1'b1;
          // Reload after the first repeat so later repeats come every RPT_PER intervals.
          if (RPT_DLY > 0 && (&ivl_q)) begin
            if (rpt_inc == RPT_TOP) begin
              rpt_hit_d = 1'b1;
              rpt_d     = RPT_RELOAD;
            end else begin
              rpt_d = rpt_inc;
            end
          end
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync)        state_d = ST_HELD;
        else if (&dbc_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Event outputs are derived from the settled state, one cycle after the transition.
    dpb_d  = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
    ccen_d = (state_q == ST_HELD);
    scen_d = (state_q == ST_HELD) && (prev_q == ST_PRESS_WAIT);
    mcen_d = scen_d || (rpt_hit_q && (state_q == ST_HELD));
    rcen_d = (state_q == ST_IDLE) && (prev_q == ST_RELEASE_WAIT);
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      sync_q    <= '0;
      state_q   <= ST_IDLE;
      prev_q    <= ST_IDLE;
      dbc_q     <= '0;
      ivl_q     <= '0;
      rpt_q     <= '0;
      rpt_hit_q <= 1'b0;
      dpb_q     <= 1'b0;
      scen_q    <= 1'b0;
      mcen_q    <= 1'b0;
      ccen_q    <= 1'b0;
      rcen_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      prev_q    <= prev_d;
      dbc_q     <= dbc_d;
      ivl_q     <= ivl_d;
      rpt_q     <= rpt_d;
      rpt_hit_q <= rpt_hit_d;
      dpb_q     <= dpb_d;
      scen_q    <= scen_d;
      mcen_q    <= mcen_d;
      ccen_q    <= ccen_d;
      rcen_q    <= rcen_d;
    end
  end

  assign dpb      = dpb_q;
  assign scen     = scen_q;
  assign mcen     = mcen_q;
  assign ccen     = ccen_q;
  assign rcen     = rcen_q;
  assign scen_nxt = scen_d;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - N_CH independent debounced push-button channels with press summary
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N_CH    = 5,
  parameter int N_DC    = 20,
  parameter int RPT_DLY = 8,
  parameter int RPT_PER = 2
) (
  input  logic            ClkPort,
  input  logic            Reset,
  input  logic [N_CH-1:0] PB,
  output logic [N_CH-1:0] DPB,
  output logic [N_CH-1:0] SCEN,
  output logic [N_CH-1:0] MCEN,
  output logic [N_CH-1:0] CCEN,
  output logic [N_CH-1:0] RCEN,
  output logic            any_press
);

  if (!params_ok(N_CH, N_DC, RPT_DLY, RPT_PER)) begin : g_param_check
    $error("btn_conditioner: illegal parameter combination");
  end

  logic [N_CH-1:0] scen_nxt;
  logic            any_press_d, any_press_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_cond_ch #(
      .N_DC    (N_DC),
      .RPT_DLY (RPT_DLY),
      .RPT_PER (RPT_PER)
    ) u_ch (
      .ClkPort  (ClkPort),
      .Reset    (Reset),
      .pb       (PB[i]),
      .dpb      (DPB[i]),
      .scen     (SCEN[i]),
      .mcen     (MCEN[i]),
      .ccen     (CCEN[i]),
      .rcen     (RCEN[i]),
      .scen_nxt (scen_nxt[i])
    );
  end

  // Registered from the channels' next-cycle SCEN so it lines up with SCEN exactly.
  always_comb begin
    any_press_d = |scen_nxt;
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) any_press_q <= 1'b0;
    else       any_press_q <= any_press_d;
  end

  assign any_press = any_press_q;

endmodule
